// File: rtl/memory_serial_controller_if.sv
// Host-side command/response bundle for the memory serial controller.
interface memory_serial_controller_if #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [DATA_SIZE-1:0] cmd_data;
  logic [GEN_WIDTH-1:0] cmd_gens;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_SIZE-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_gens, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_gens, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/memory_serial_controller.sv
// Sequences serial LOAD / circular READ / RUN on the system memory and
// deserializes the readout into a parallel response.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// LOAD    | load_mode high, shifting the word out MSB first
// READ    | output_mode high for DATA_SIZE cycles (full rotation)
// DRAIN   | one extra cycle to capture the last registered bit
// RESP    | rsp_valid high until rsp_ready
// RUN     | run_mode high for cmd_gens cycles
module memory_serial_controller #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  memory_serial_controller_if.slave  bus,
  output logic                       mem_serial_in,
  input  logic                       mem_serial_out,
  output logic                       load_mode,
  output logic                       output_mode,
  output logic                       run_mode,
  output logic                       busy
);

  localparam int CNT_W = (GEN_WIDTH > $clog2(DATA_SIZE)) ? GEN_WIDTH : $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_DRAIN, S_RESP, S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] cap_q, cap_d;
  logic [DATA_SIZE-1:0] rsp_q, rsp_d;
  logic                 sample_q;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      cap_q    <= '0;
      rsp_q    <= '0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      rsp_q    <= rsp_d;
      // memory output is registered, so its bit is valid one cycle after output_mode
      sample_q <= (state_q == S_READ);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    accept  = bus.cmd_valid && bus.cmd_ready;

    if (sample_q) cap_d = {cap_q[DATA_SIZE-2:0], mem_serial_out};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            2'd0: begin
              state_d = S_LOAD;
              shift_d = bus.cmd_data;
              cnt_d   = CNT_LAST;
            end
            2'd1: begin
              state_d = S_READ;
              cnt_d   = CNT_LAST;
            end
            2'd2: begin
              if (bus.cmd_gens != '0) begin
                state_d = S_RUN;
                cnt_d   = CNT_W'(bus.cmd_gens) - CNT_ONE;
              end
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        shift_d = {shift_q[DATA_SIZE-2:0], 1'b0};
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_READ: begin
        if (cnt_q == '0) state_d = S_DRAIN;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_DRAIN: begin
        state_d = S_RESP;
        rsp_d   = {cap_q[DATA_SIZE-2:0], mem_serial_out};
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load_mode     = (state_q == S_LOAD);
  assign output_mode   = (state_q == S_READ);
  assign run_mode      = (state_q == S_RUN);
  assign busy          = (state_q != S_IDLE);
  assign mem_serial_in = load_mode & shift_q[DATA_SIZE-1];
  assign bus.cmd_ready = (state_q == S_IDLE) && reset;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_q;

endmodule

// File: doc/memory_serial_controller.md
Name: memory_serial_controller

Overview:
- Host-side end of the system memory's serial load/readout interface.
- Accepts parallel commands over a valid/ready handshake: LOAD a word, READ the word back, or RUN N generations.
- Sequences load_mode, output_mode, run_mode and the serial bit stream to the memory, and deserializes the memory's serial output into a parallel response.
- Guarantees a READ uses exactly DATA_SIZE output_mode cycles, so the memory's circular readout leaves its contents intact.

Parameters:
DATA_SIZE, 64, width of the memory word / grid (>= 2)
GEN_WIDTH, 16, width of the generation-count field

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  0=LOAD, 1=READ, 2=RUN, 3=NOP
cmd_data  input  DATA_SIZE  word to load (LOAD only)
cmd_gens  input  GEN_WIDTH  run_mode cycle count (RUN only)
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts rsp_data
rsp_data  output  DATA_SIZE  word read from memory
mem_serial_in  output  1  serial bit to memory serial input
mem_serial_out  input  1  memory registered serial output
load_mode  output  1  memory load enable
output_mode  output  1  memory readout enable
run_mode  output  1  memory grid-capture enable
busy  output  1  state != IDLE

Behaviour:
- All outputs are registered or decoded from the state register.
- load_mode, output_mode and run_mode are mutually exclusive at all times.
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - load_mode, output_mode, run_mode, mem_serial_in, rsp_valid, busy = 0.
  - rsp_data = 0, all counters = 0.
  - cmd_ready is forced 0 while reset=0.
  - Reset mid-operation aborts at that edge; modes drop immediately.
  - Memory contents after an aborted LOAD or READ are undefined; no recovery is attempted.
- States: IDLE, LOAD, READ, DRAIN, RESP, RUN.
- cmd_ready = (state==IDLE) && reset. A command is accepted on an edge with cmd_valid && cmd_ready.
- IDLE, on accept:
  - LOAD -> shift reg <= cmd_data, cnt <= DATA_SIZE-1.
  - READ -> cnt <= DATA_SIZE-1.
  - RUN with cmd_gens != 0 -> cnt <= cmd_gens-1.
  - RUN with cmd_gens == 0, or NOP -> consumed, stay IDLE (no mode pulse).
- LOAD:
  - load_mode=1 for exactly DATA_SIZE cycles.
  - mem_serial_in = current shift-reg MSB; shift left each cycle, so cmd_data is sent MSB first.
  - After the cnt==0 cycle -> IDLE; mem_serial_in returns to 0.
  - After the LOAD the memory holds cmd_data.
- READ:
  - output_mode=1 for exactly DATA_SIZE cycles (cnt down to 0), then -> DRAIN.
  - Memory updates mem_serial_out at the edge ending each output_mode cycle.
  - The controller shifts mem_serial_out into the capture reg LSB at the edge ending each cycle following an output_mode cycle: READ cycles 2..DATA_SIZE plus DRAIN, DATA_SIZE samples total.
  - The first sample lands MSB-first, so the capture reg equals the pre-read memory word.
- DRAIN: output_mode=0 for one cycle; take the last sample; load rsp_data; -> RESP.
- RESP:
  - rsp_valid=1 with rsp_data held stable until rsp_ready=1 at an edge.
  - Then rsp_valid <= 0 -> IDLE. rsp_data keeps its value until the next READ.
  - If rsp_ready is already 1 on the first RESP cycle, RESP lasts one cycle.
- RUN: run_mode=1 for exactly cmd_gens cycles, then -> IDLE.
- No new command is accepted while busy; cmd_ready is low.
- A LOAD with in-flight backpressure on rsp is impossible, since RESP blocks.
- Command-to-ready latencies:
  - LOAD: DATA_SIZE+1 cycles.
  - READ: DATA_SIZE+2 cycles plus RESP wait.
  - RUN: cmd_gens+1 cycles.
- Unknown or NOP commands have no side effects.

Test Plan:
- DATA_SIZE=8 for all scenarios.
- LOAD 0xA5 -> load_mode high exactly 8 cycles; mem_serial_in sequence 1,0,1,0,0,1,0,1; memory model holds 0xA5.
- LOAD 0xA5, READ, READ -> output_mode high exactly 8 cycles each; both responses rsp_data=0xA5; memory still 0xA5.
- READ with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and rsp_data=0xA5 stable; cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- RUN cmd_gens=3 with memory grid_in=0x3C -> run_mode high exactly 3 cycles; a subsequent READ returns 0x3C. RUN with cmd_gens=0 and NOP -> no mode pulse, cmd_ready stays 1.
- reset=0 on the 4th load_mode cycle -> at that edge all modes 0, busy=0, rsp_valid=0; cmd_ready=0 until reset=1, then 1; a fresh LOAD 0xFF then READ returns 0xFF.
- Random command stream (1000 cmds) against a memory reference model -> never two modes high at once; every READ matches the model.
